// File: rtl/i2s_tx_ctrl.sv
// I2S master transmitter: BCLK/LRCK generation, one-entry sample hold, MSB-first shifter.
// Optional underrun counter port enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_ctrl #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] smp_l,
  input  logic [SAMPLE_WIDTH-1:0] smp_r,
  input  logic                    smp_valid,
  output logic                    smp_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_dout,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int unsigned BCLK_HALF  = CLK_FREQ / (SAMPLE_RATE * SLOT_WIDTH * 2) / 2;
  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d, bit_nxt;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    dout_q, dout_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                    ready_q, ready_d;
  logic                    underrun_q, underrun_d;

  logic                    div_wrap, fall, frame_wrap, xfer;
  logic [SLOT_WIDTH-1:0]   slot_l, slot_r;

  assign div_wrap   = (div_q == DIV_W'(BCLK_HALF - 1));
  assign fall       = (state_q != IDLE) && div_wrap && bclk_q;
  assign frame_wrap = fall && (bit_q == BIT_W'(FRAME_BITS - 1));
  assign bit_nxt    = frame_wrap ? '0 : bit_q + BIT_W'(1);
  assign xfer       = smp_valid && ready_q;

  // Left-justify each sample in its slot; the remaining pad bits are zero.
  assign slot_l = SLOT_WIDTH'(hold_l_q) << (SLOT_WIDTH - SAMPLE_WIDTH);
  assign slot_r = SLOT_WIDTH'(hold_r_q) << (SLOT_WIDTH - SAMPLE_WIDTH);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bclk_d      = bclk_q;
    bit_d       = bit_q;
    lrck_d      = lrck_q;
    dout_d      = dout_q;
    sr_d        = sr_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    ready_d     = ready_q;
    underrun_d  = 1'b0;

    if (!en) begin
      state_d     = IDLE;
      div_d       = '0;
      bclk_d      = 1'b0;
      bit_d       = '0;
      lrck_d      = 1'b0;
      dout_d      = 1'b0;
      sr_d        = '0;
      hold_full_d = 1'b0;
      hold_l_d    = '0;
      hold_r_d    = '0;
      ready_d     = 1'b0;
    end else begin
      if (state_q == IDLE) begin
        state_d = PREFILL;
      end else begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) bclk_d = ~bclk_q;

        if (fall) begin
          bit_d  = bit_nxt;
          dout_d = sr_q[FRAME_BITS-1];
          sr_d   = sr_q << 1;
          if (bit_nxt == BIT_W'(SLOT_WIDTH)) lrck_d = 1'b1;
          else if (frame_wrap)               lrck_d = 1'b0;
        end

        // The frame takes the hold contents from before this cycle; a pair
        // accepted on the same cycle is kept for the next frame.
        if (frame_wrap) begin
          if (hold_full_q) begin
            sr_d        = {slot_l, slot_r};
            hold_full_d = 1'b0;
          end else begin
            sr_d       = '0;
            underrun_d = (state_q == RUN);
          end
          if (state_q == PREFILL) state_d = RUN;
        end
      end

      if (xfer) begin
        hold_full_d = 1'b1;
        hold_l_d    = smp_l;
        hold_r_d    = smp_r;
      end
      ready_d = ~hold_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_q       <= '0;
      lrck_q      <= 1'b0;
      dout_q      <= 1'b0;
      sr_q        <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_q       <= bit_d;
      lrck_q      <= lrck_d;
      dout_q      <= dout_d;
      sr_q        <= sr_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
    end
  end

  assign smp_ready = ready_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_dout  = dout_q;
  assign underrun  = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en)                            cnt_d = '0;
    else if (underrun_d && cnt_q != '1) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed self-checking bench for i2s_tx_ctrl; dout is captured one bit per BCLK fall.
module tb_i2s_tx_ctrl;

  localparam int K_BRISE = 0;
  localparam int K_BFALL = 1;
  localparam int K_LFALL = 2;

  logic        clk = 1'b0;
  logic        reset, en, smp_valid;
  logic [15:0] smp_l, smp_r;
  logic        smp_ready, i2s_bclk, i2s_lrck, i2s_dout, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prev_bclk, prev_lrck, prev_ur;
  bit bclk_fall, bclk_rise, lrck_fall;
  int lrck_off = 0;
  int ur_wide = 0;
  bit feed = 0;

  always #5 clk = ~clk;

  i2s_tx_ctrl #(
    .CLK_FREQ    (50_000_000),
    .SAMPLE_RATE (48000),
    .SAMPLE_WIDTH(16),
    .SLOT_WIDTH  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .smp_l    (smp_l),
    .smp_r    (smp_r),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_dout (i2s_dout),
    .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bclk_fall = prev_bclk && !i2s_bclk;
    bclk_rise = !prev_bclk && i2s_bclk;
    lrck_fall = prev_lrck && !i2s_lrck;
    if ((prev_lrck != i2s_lrck) && !bclk_fall) lrck_off++;
    if (underrun && prev_ur) ur_wide++;
    prev_bclk = i2s_bclk;
    prev_lrck = i2s_lrck;
    prev_ur   = underrun;
    if (feed) smp_valid = smp_ready;
  endtask

  task automatic wait_edge(input int kind, input int budget, input string tag, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (kind)
        K_BRISE: hit = bclk_rise;
        K_BFALL: hit = bclk_fall;
        default: hit = lrck_fall;
      endcase
    end
    if (!hit) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // Captures the 64 bits of the frame that starts after the current point.
  task automatic capture_frame(output logic [31:0] l, output logic [31:0] r,
                               output int lr_bad, output int urs);
    int n;
    l = '0;
    r = '0;
    lr_bad = 0;
    urs = 0;
    for (int i = 1; i <= 64; i++) begin
      n = 0;
      do begin
        tick();
        n++;
        if (underrun) urs++;
      end while (!bclk_fall && n < 40);
      if (!bclk_fall) lr_bad++;
      if (i <= 32) l = {l[30:0], i2s_dout};
      else         r = {r[30:0], i2s_dout};
      if (i2s_lrck !== ((i >= 32 && i <= 63) ? 1'b1 : 1'b0)) lr_bad++;
    end
  endtask

  initial begin
    int n, stamp, lr_bad, urs, bad;
    logic [31:0] l, r;

    // T1: reset and idle
    reset = 1'b1; en = 1'b0; smp_valid = 1'b0; smp_l = '0; smp_r = '0;
    repeat (5) tick();
    reset = 1'b0;
    check("reset outputs", {27'd0, i2s_bclk, i2s_lrck, i2s_dout, smp_ready, underrun}, 32'd0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if ({i2s_bclk, i2s_lrck, i2s_dout, smp_ready, underrun} !== 5'd0) bad++;
    end
    check("idle 2000 clks nonzero count", bad, 0);

    // T2: clocking, with the pair supplied whenever ready is high
    smp_l = 16'hA5C3; smp_r = 16'h0F01; feed = 1; en = 1'b1;
    wait_edge(K_BRISE, 40, "first bclk rise", n);
    wait_edge(K_BFALL, 40, "bclk fall", n);
    check("bclk high clks", n, 8);
    wait_edge(K_BRISE, 40, "bclk rise", n);
    check("bclk low clks", n, 8);
    wait_edge(K_LFALL, 3000, "first frame wrap", n);
    check("prefill wrap underrun", underrun, 1'b0);
    stamp = cyc;

    // T3: data frames
    capture_frame(l, r, lr_bad, urs);
    check("lrck period clks", cyc - stamp, 1024);
    check("t3 f1 left", l, 32'hA5C3_0000);
    check("t3 f1 right", r, 32'h0F01_0000);
    check("t3 f1 lrck shape", lr_bad, 0);
    check("t3 f1 underruns", urs, 0);
    capture_frame(l, r, lr_bad, urs);
    check("t3 f2 left", l, 32'hA5C3_0000);
    check("t3 f2 right", r, 32'h0F01_0000);
    check("t3 f2 underruns", urs, 0);

    // T4: flush, then run with no samples supplied
    feed = 0; smp_valid = 1'b0; en = 1'b0;
    tick();
    check("t4 disabled outputs", {27'd0, i2s_bclk, i2s_lrck, i2s_dout, smp_ready, underrun}, 32'd0);
    en = 1'b1;
    wait_edge(K_LFALL, 3000, "t4 wrap1", n);
    check("t4 wrap1 underrun", underrun, 1'b0);
    capture_frame(l, r, lr_bad, urs);
    check("t4 f1 silent", {l | r}, 32'd0);
    check("t4 f1 underruns", urs, 1);
    check("t4 wrap2 underrun", underrun, 1'b1);
    capture_frame(l, r, lr_bad, urs);
    check("t4 f2 underruns", urs, 1);
    capture_frame(l, r, lr_bad, urs);
    check("t4 f3 underruns", urs, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t4 underrun_cnt", underrun_cnt, 32'd3);
`endif

    // T5: pair offered on exactly the frame-wrap clk
    repeat (1023) tick();
    smp_l = 16'h8001; smp_r = 16'h7FFE; smp_valid = 1'b1;
    tick();
    check("t5 wrap aligned", lrck_fall, 1'b1);
    check("t5 wrap underrun", underrun, 1'b1);
    check("t5 ready after xfer", smp_ready, 1'b0);
    smp_valid = 1'b0;
    capture_frame(l, r, lr_bad, urs);
    check("t5 wrap frame silent", {l | r}, 32'd0);
    check("t5 wrap frame underruns", urs, 0);
    capture_frame(l, r, lr_bad, urs);
    check("t5 next left", l, 32'h8001_0000);
    check("t5 next right", r, 32'h7FFE_0000);
    check("t5 next underruns", urs, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t5 underrun_cnt", underrun_cnt, 32'd5);
`endif

    // T6: en dropped at bit_cnt=20 while bclk is high
    repeat (20) wait_edge(K_BFALL, 40, "t6 bit fall", n);
    wait_edge(K_BRISE, 40, "t6 rise", n);
    check("t6 bclk before drop", i2s_bclk, 1'b1);
    check("t6 ready before drop", smp_ready, 1'b1);
    en = 1'b0;
    tick();
    check("t6 outputs after drop", {27'd0, i2s_bclk, i2s_lrck, i2s_dout, smp_ready, underrun}, 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t6 cnt cleared", underrun_cnt, 32'd0);
`endif
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({i2s_bclk, i2s_lrck, i2s_dout, smp_ready, underrun} !== 5'd0) bad++;
    end
    check("t6 stays idle", bad, 0);
    en = 1'b1;
    wait_edge(K_LFALL, 3000, "t6 wrap1", n);
    check("t6 prefill wrap underrun", underrun, 1'b0);
    capture_frame(l, r, lr_bad, urs);
    check("t6 f1 silent", {l | r}, 32'd0);
    check("t6 f1 underruns", urs, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t6 underrun_cnt", underrun_cnt, 32'd1);
`endif

    check("lrck changes off bclk fall", lrck_off, 0);
    check("underrun wider than 1 clk", ur_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
